musa_alu: RTL and testbench



---
 rtl/musa_alu_pkg.sv | 30 +++
 rtl/musa_alu_core.sv | 109 ++++++++++
 rtl/musa_alu.sv | 54 +++++
 tb/tb_musa_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/musa_alu_pkg.sv
// ============================================================================
// Module      : musa_alu_pkg
// Description : Shared constants for the MUSA execute-stage ALU (func codes,
//               flag bit positions, datapath width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package musa_alu_pkg;

  localparam int WIDTH  = 32;
  localparam int FUNC_W = 6;
  localparam int FLAG_W = 3;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 6'b100000;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 6'b100010;
  localparam logic [FUNC_W-1:0] FUNC_MUL  = 6'b011000;
  localparam logic [FUNC_W-1:0] FUNC_DIV  = 6'b011010;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 6'b100100;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 6'b100101;
  localparam logic [FUNC_W-1:0] FUNC_NOT  = 6'b100111;
  localparam logic [FUNC_W-1:0] FUNC_BRFL = 6'b111111;

  localparam int FLAG_ABOVE    = 2;
  localparam int FLAG_EQUALS   = 1;
  localparam int FLAG_OVERFLOW = 0;

endpackage

`default_nettype wire

// File: rtl/musa_alu_core.sv
// ============================================================================
// Module      : musa_alu_core
// Description : Combinational datapath and flag logic of the MUSA ALU.
//               Divider present only when MUSA_ALU_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module musa_alu_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [5:0]       func,
  input  logic [2:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags_out
);
  import musa_alu_pkg::*;

  logic [WIDTH-1:0]          w_sum;
  logic [WIDTH-1:0]          w_diff;
  logic signed [2*WIDTH-1:0] w_prod;
  logic                      w_add_ovf;
  logic                      w_sub_ovf;
  logic                      w_mul_ovf;
  logic [2:0]                w_cmp_flags;
  logic                      w_brfl_hit;

  assign w_sum  = op1 + op2;
  assign w_diff = op1 - op2;
  assign w_prod = $signed({{WIDTH{op1[WIDTH-1]}}, op1}) * $signed({{WIDTH{op2[WIDTH-1]}}, op2});

  assign w_add_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1] != op1[WIDTH-1]);
  assign w_sub_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_diff[WIDTH-1] != op1[WIDTH-1]);
  assign w_mul_ovf = w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}};

  // A zero mask must not match, otherwise every brfl with op2=0 would branch
  assign w_brfl_hit = (op2[2:0] != 3'b000) && ((flags_in & op2[2:0]) == op2[2:0]);

  always_comb begin
    w_cmp_flags                = '0;
    w_cmp_flags[FLAG_ABOVE]    = $signed(op1) > $signed(op2);
    w_cmp_flags[FLAG_EQUALS]   = op1 == op2;
  end

`ifdef MUSA_ALU_DIV_EN
  localparam logic [WIDTH-1:0] c_int_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_den;
  logic [WIDTH-1:0] w_quot;

  assign w_div_zero = op2 == '0;
  assign w_div_ovf  = (op1 == c_int_min) && (op2 == '1);
  // Divide by one in both trap cases: MIN/1 yields the required MIN result
  assign w_den      = (w_div_zero || w_div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : op2;
  assign w_quot     = $signed(op1) / $signed(w_den);
`endif

  always_comb begin
    result    = '0;
    flags_out = flags_in;
    case (func)
      FUNC_ADD: begin
        result                   = w_sum;
        flags_out                = w_cmp_flags;
        flags_out[FLAG_OVERFLOW] = w_add_ovf;
      end
      FUNC_SUB: begin
        result                   = w_diff;
        flags_out                = w_cmp_flags;
        flags_out[FLAG_OVERFLOW] = w_sub_ovf;
      end
      FUNC_MUL: begin
        result                   = w_prod[WIDTH-1:0];
        flags_out                = w_cmp_flags;
        flags_out[FLAG_OVERFLOW] = w_mul_ovf;
      end
`ifdef MUSA_ALU_DIV_EN
      FUNC_DIV: begin
        result                   = w_div_zero ? '0 : w_quot;
        flags_out                = w_cmp_flags;
        flags_out[FLAG_OVERFLOW] = w_div_zero || w_div_ovf;
      end
`endif
      FUNC_AND: begin
        result    = op1 & op2;
        flags_out = w_cmp_flags;
      end
      FUNC_OR: begin
        result    = op1 | op2;
        flags_out = w_cmp_flags;
      end
      FUNC_NOT: begin
        result    = ~op1;
        flags_out = w_cmp_flags;
      end
      FUNC_BRFL: begin
        result = {{(WIDTH-1){1'b0}}, w_brfl_hit};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/musa_alu.sv
// ============================================================================
// Module      : musa_alu
// Description : MUSA execute-stage ALU top: combinational core plus the
//               result/flag output register. Optional divider: MUSA_ALU_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module musa_alu #(
  parameter int WIDTH = musa_alu_pkg::WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                op1,
  input  logic [WIDTH-1:0]                op2,
  input  logic [musa_alu_pkg::FUNC_W-1:0] func,
  input  logic [musa_alu_pkg::FLAG_W-1:0] flags_in,
  output logic [WIDTH-1:0]                result,
  output logic [musa_alu_pkg::FLAG_W-1:0] flags_out
);
  import musa_alu_pkg::*;

  logic [WIDTH-1:0]  w_result;
  logic [FLAG_W-1:0] w_flags;
  logic [WIDTH-1:0]  r_result;
  logic [FLAG_W-1:0] r_flags;

  musa_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op1       (op1),
    .op2       (op2),
    .func      (func),
    .flags_in  (flags_in),
    .result    (w_result),
    .flags_out (w_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign result    = r_result;
  assign flags_out = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_musa_alu.sv
// ============================================================================
// Module      : tb_musa_alu
// Description : Scoreboard bench for musa_alu; reference model works on true
//               integer ranges. Follows MUSA_ALU_DIV_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_musa_alu;

  localparam longint c_int_max = 64'sd2147483647;
  localparam longint c_int_min = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [5:0]  func = '0;
  logic [2:0]  flags_in = '0;
  logic [31:0] result;
  logic [2:0]  flags_out;

  typedef struct {
    int          id;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  fl;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   total = 0;
  int   bad = 0;
  int   n_issued = 0;

  musa_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .op1       (op1),
    .op2       (op2),
    .func      (func),
    .flags_in  (flags_in),
    .result    (result),
    .flags_out (flags_out)
  );

  always #5 clk = ~clk;

  // Reference: arithmetic done in 64-bit integers, overflow = leaves 32-bit range
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [5:0] f, input logic [2:0] fi,
                                output logic [31:0] r, output logic [2:0] fo);
    int signed   sa;
    int signed   sb;
    longint      wide;
    logic [63:0] wbits;
    logic        above;
    logic        eq;
    logic        ovf;
    logic        cmp;
    sa = a;
    sb = b;
    above = sa > sb;
    eq = a == b;
    ovf = 1'b0;
    cmp = 1'b1;
    r = '0;
    fo = fi;
    wide = 0;
    case (f)
      6'b100000, 6'b100010, 6'b011000: begin
        if (f == 6'b100000)      wide = longint'(sa) + longint'(sb);
        else if (f == 6'b100010) wide = longint'(sa) - longint'(sb);
        else                     wide = longint'(sa) * longint'(sb);
        wbits = wide;
        r = wbits[31:0];
        ovf = (wide > c_int_max) || (wide < c_int_min);
      end
`ifdef MUSA_ALU_DIV_EN
      6'b011010: begin
        if (sb == 0) begin
          r = '0;
          ovf = 1'b1;
        end else begin
          wide = longint'(sa) / longint'(sb);
          wbits = wide;
          r = wbits[31:0];
          ovf = wide > c_int_max;
        end
      end
`endif
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100111: r = ~a;
      6'b111111: begin
        cmp = 1'b0;
        r = ((b[2:0] != 3'b000) && ((fi & b[2:0]) == b[2:0])) ? 32'd1 : 32'd0;
      end
      default: cmp = 1'b0;
    endcase
    if (cmp) fo = {above, eq, ovf};
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] fi);
    exp_t e;
    @(negedge clk);
    func = f;
    op1 = a;
    op2 = b;
    flags_in = fi;
    e.id = n_issued;
    e.f = f;
    e.a = a;
    e.b = b;
    model(a, b, f, fi, e.r, e.fl);
    n_issued++;
    q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [31:0] r, input logic [2:0] fl);
    total++;
    if (result !== r || flags_out !== fl) begin
      bad++;
      $display("FAIL %s: result got=%h exp=%h flags got=%b exp=%b", name, result, r, flags_out, fl);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: every registered output corresponds to the oldest queued op
  always begin
    @(posedge clk);
    #1;
    if (!rst && q.size() > 0) begin
      m_e = q.pop_front();
      total++;
      if (result !== m_e.r || flags_out !== m_e.fl) begin
        bad++;
        $display("FAIL op#%0d func=%b a=%h b=%h: result got=%h exp=%h flags got=%b exp=%b",
                 m_e.id, m_e.f, m_e.a, m_e.b, result, m_e.r, flags_out, m_e.fl);
      end
    end
  end

  logic [5:0] codes [10];

  initial begin
    codes = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b100100,
              6'b100101, 6'b100111, 6'b111111, 6'b000000, 6'b010101};

    #2 rst = 1'b1;
    #1 check_now("reset_init", 32'd0, 3'b000);
    repeat (2) @(negedge clk);
    check_now("reset_hold", 32'd0, 3'b000);
    rst = 1'b0;

    issue(6'b100000, 32'd5, 32'd3, 3'b000);
    issue(6'b100000, 32'h7FFF_FFFF, 32'd1, 3'b000);
    issue(6'b100010, 32'd7, 32'd7, 3'b000);
    issue(6'b011000, -32'sd3, 32'd4, 3'b000);
    issue(6'b011000, 32'h0001_0000, 32'h0001_0000, 3'b000);
    issue(6'b011010, 32'd7, -32'sd2, 3'b000);
    issue(6'b011010, 32'd5, 32'd0, 3'b000);
    issue(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 3'b000);
    issue(6'b011010, 32'd7, -32'sd2, 3'b011);
    issue(6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111);
    issue(6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111);
    issue(6'b100111, 32'd0, 32'h1234_5678, 3'b111);
    issue(6'b111111, 32'd9, 32'b010, 3'b110);
    issue(6'b111111, 32'd9, 32'b001, 3'b110);
    issue(6'b111111, 32'd9, 32'b000, 3'b110);
    issue(6'b000000, 32'd9, 32'd4, 3'b110);

    // Reset between edges while an add is in flight
    issue(6'b100000, 32'd100, 32'd23, 3'b000);
    #2 rst = 1'b1;
    q.delete();
    #1 check_now("reset_async", 32'd0, 3'b000);
    @(negedge clk);
    check_now("reset_discard", 32'd0, 3'b000);
    rst = 1'b0;
    issue(6'b100000, 32'd5, 32'd3, 3'b000);

    for (int i = 0; i < 400; i++) begin
      logic [5:0]  f;
      logic [31:0] b;
      f = codes[$urandom_range(0, 9)];
      if (f == 6'b010101) f = 6'($urandom());
      b = (f == 6'b111111) ? 32'($urandom_range(0, 7)) : rnd_op();
      issue(f, rnd_op(), b, 3'($urandom()));
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending got=%0d exp=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
